// File: rtl/spi_reg_ctrl.sv
// Command/byte sequencer between an SPI slave byte interface and a register bank.
// Reads are prefetched for the next byte; errors are sticky until reset or an 8'hFF command.
module spi_reg_ctrl #(
   parameter int          AW            = 7,
   parameter int          TIMEOUT       = 16,
   parameter logic [7:0]  UNDERRUN_FILL = 8'hEE
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          sel,
   input  logic          byte_valid,
   input  logic [7:0]    mdat,
   output logic [7:0]    sdat,
   output logic [AW-1:0] reg_addr,
   output logic [7:0]    reg_wdata,
   output logic          reg_we,
   output logic          reg_re,
   input  logic [7:0]    reg_rdata,
   input  logic          reg_ack,
   output logic          busy,
   output logic [2:0]    err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_HOLD} state_t;

   state_t        state, state_n;
   logic          sel_q;
   logic          discard, discard_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0]    sdat_n, wdata_n;
   logic [AW-1:0] addr_n;
   logic          we_n, re_n;
   logic [2:0]    err_n;
   logic          req, ack_v, tmo, done;

   assign req   = reg_we | reg_re;
   assign ack_v = req & reg_ack;
   assign tmo   = req & ~reg_ack & (cnt == CW'(TIMEOUT - 1));
   assign done  = ack_v | tmo;
   assign busy  = (state != IDLE) && (state != CMD);

   always_comb begin
      state_n   = state;
      sdat_n    = sdat;
      addr_n    = reg_addr;
      wdata_n   = reg_wdata;
      we_n      = reg_we;
      re_n      = reg_re;
      err_n     = err;
      discard_n = discard;
      cnt_n     = (req && !done) ? cnt + CW'(1) : '0;

      if (!sel) begin
         state_n   = IDLE;
         we_n      = 1'b0;
         re_n      = 1'b0;
         discard_n = 1'b0;
         cnt_n     = '0;
      end else begin
         case (state)
            IDLE: begin
               // Only a fresh rising sel starts a frame; after 8'hFF we sit here until sel drops.
               if (!sel_q) state_n = CMD;
            end
            CMD: begin
               if (byte_valid) begin
                  addr_n = mdat[AW-1:0];
                  if (mdat == 8'hFF) begin
                     err_n   = '0;
                     state_n = IDLE;
                  end else if (mdat[7]) begin
                     re_n    = 1'b1;
                     state_n = RD_BUS;
                  end else begin
                     sdat_n  = 8'h00;
                     state_n = WR_WAIT;
                  end
               end else begin
                  sdat_n = {5'b0, err};
               end
            end
            WR_WAIT: begin
               if (byte_valid) begin
                  wdata_n = mdat;
                  we_n    = 1'b1;
                  sdat_n  = 8'h00;
                  state_n = WR_BUS;
               end
            end
            WR_BUS: begin
               // Request drops for one cycle after an ack that coincided with a new byte.
               if (!reg_we) we_n = 1'b1;
               if (done) begin
                  we_n    = 1'b0;
                  addr_n  = reg_addr + AW'(1);
                  state_n = WR_WAIT;
                  if (tmo) err_n[2] = 1'b1;
                  if (byte_valid) begin
                     wdata_n = mdat;
                     sdat_n  = 8'h00;
                     state_n = WR_BUS;
                  end
               end else if (byte_valid) begin
                  err_n[0] = 1'b1;
                  sdat_n   = 8'h00;
               end
            end
            RD_BUS: begin
               if (!reg_re) re_n = 1'b1;
               if (done) begin
                  re_n = 1'b0;
                  if (tmo) err_n[2] = 1'b1;
                  if (discard) begin
                     discard_n = 1'b0;
                     addr_n    = reg_addr + AW'(1);
                  end else begin
                     sdat_n  = tmo ? 8'h00 : reg_rdata;
                     state_n = RD_HOLD;
                  end
               end else if (byte_valid) begin
                  err_n[1]  = 1'b1;
                  sdat_n    = UNDERRUN_FILL;
                  discard_n = 1'b1;
               end
            end
            RD_HOLD: begin
               if (byte_valid) begin
                  addr_n  = reg_addr + AW'(1);
                  re_n    = 1'b1;
                  state_n = RD_BUS;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         sel_q     <= 1'b0;
         sdat      <= 8'h00;
         reg_addr  <= '0;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         err       <= 3'b000;
         discard   <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_n;
         sel_q     <= sel;
         sdat      <= sdat_n;
         reg_addr  <= addr_n;
         reg_wdata <= wdata_n;
         reg_we    <= we_n;
         reg_re    <= re_n;
         err       <= err_n;
         discard   <= discard_n;
         cnt       <= cnt_n;
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table-driven bursts plus hand-written error/abort sequences.
module tb_spi_reg_ctrl;

   logic       clk, reset_n, sel, byte_valid, reg_ack, reg_we, reg_re, busy;
   logic [7:0] mdat, sdat, reg_wdata, reg_rdata;
   logic [6:0] reg_addr;
   logic [2:0] err;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [128];
   logic [6:0] wlog_a[$];
   logic [7:0] wlog_d[$];
   int         ack_dly = 1;
   bit         ack_en  = 1'b1;
   int         wait_cnt;

   spi_reg_ctrl #(.AW(7), .TIMEOUT(16), .UNDERRUN_FILL(8'hEE)) dut (
      .clk(clk), .reset_n(reset_n), .sel(sel), .byte_valid(byte_valid), .mdat(mdat),
      .sdat(sdat), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_re(reg_re), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .busy(busy), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Register bank model: acks ack_dly+1 cycles after a request is raised.
   initial begin
      reg_ack   = 1'b0;
      reg_rdata = 8'h00;
      wait_cnt  = 0;
      forever begin
         @(negedge clk);
         reg_ack = 1'b0;
         if ((reg_we || reg_re) && ack_en) begin
            if (wait_cnt == ack_dly) begin
               reg_ack  = 1'b1;
               wait_cnt = 0;
               if (reg_we) begin
                  mem[reg_addr] = reg_wdata;
                  wlog_a.push_back(reg_addr);
                  wlog_d.push_back(reg_wdata);
               end else begin
                  reg_rdata = mem[reg_addr];
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic [7:0] got);
      got        = sdat;
      mdat       = b;
      byte_valid = 1'b1;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   typedef enum int {OP_START, OP_BYTE, OP_END} op_t;
   typedef struct {
      op_t        op;
      logic [7:0] dat;
      int         gap;
      logic [7:0] exp_sdat;
      logic [2:0] exp_err;
   } vec_t;

   vec_t       tbl [13];
   logic [7:0] got;
   int         n;

   initial begin
      // write burst: A1@05, B2@06
      tbl[0]  = '{OP_START, 8'h00, 3, 8'h00, 3'b000};
      tbl[1]  = '{OP_BYTE,  8'h05, 6, 8'h00, 3'b000};
      tbl[2]  = '{OP_BYTE,  8'hA1, 6, 8'h00, 3'b000};
      tbl[3]  = '{OP_BYTE,  8'hB2, 6, 8'h00, 3'b000};
      tbl[4]  = '{OP_END,   8'h00, 3, 8'h00, 3'b000};
      // read burst from 7E with wrap to 00 (last prefetch reads 01 = 00)
      tbl[5]  = '{OP_START, 8'h00, 3, 8'h00, 3'b000};
      tbl[6]  = '{OP_BYTE,  8'hFE, 6, 8'h00, 3'b000};
      tbl[7]  = '{OP_BYTE,  8'h00, 6, 8'h11, 3'b000};
      tbl[8]  = '{OP_BYTE,  8'h00, 6, 8'h22, 3'b000};
      tbl[9]  = '{OP_BYTE,  8'h00, 6, 8'h33, 3'b000};
      tbl[10] = '{OP_END,   8'h00, 3, 8'h00, 3'b000};
      tbl[11] = '{OP_START, 8'h00, 3, 8'h00, 3'b000};
      tbl[12] = '{OP_END,   8'h00, 3, 8'h00, 3'b000};

      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[7'h7E] = 8'h11;
      mem[7'h7F] = 8'h22;
      mem[7'h00] = 8'h33;

      reset_n = 1'b0; sel = 1'b0; byte_valid = 1'b0; mdat = 8'h00;
      idle(3);
      chk("rst_sdat", sdat, 8'h00);
      chk("rst_addr", reg_addr, 7'h00);
      chk("rst_wdata", reg_wdata, 8'h00);
      chk("rst_we_re", {reg_we, reg_re}, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 3'b000);
      reset_n = 1'b1;
      idle(2);

      for (int i = 0; i < 13; i++) begin
         case (tbl[i].op)
            OP_START: begin sel = 1'b1; idle(tbl[i].gap); chk($sformatf("vec%0d_sdat", i), sdat, tbl[i].exp_sdat); end
            OP_BYTE:  begin send_byte(tbl[i].dat, got); idle(tbl[i].gap); chk($sformatf("vec%0d_sdat", i), got, tbl[i].exp_sdat); end
            default:  begin sel = 1'b0; idle(tbl[i].gap); chk($sformatf("vec%0d_sdat", i), sdat, tbl[i].exp_sdat); end
         endcase
         chk($sformatf("vec%0d_err", i), err, tbl[i].exp_err);
      end
      chk("wr_count", wlog_a.size(), 2);
      if (wlog_a.size() == 2) begin
         chk("wr0", {wlog_a[0], wlog_d[0]}, {7'h05, 8'hA1});
         chk("wr1", {wlog_a[1], wlog_d[1]}, {7'h06, 8'hB2});
      end
      wlog_a.delete(); wlog_d.delete();

      // slow ack: underrun on the first dummy byte, fill byte seen on the second
      ack_dly = 11;
      sel = 1'b1; idle(3);
      send_byte(8'h80, got); idle(7);
      send_byte(8'h00, got); idle(7);
      send_byte(8'h00, got);
      chk("underrun_fill", got, 8'hEE);
      chk("underrun_err", err, 3'b010);
      sel = 1'b0; @(negedge clk);
      chk("abort_re_slow", reg_re, 1'b0);
      idle(2);
      sel = 1'b1; idle(3);
      chk("status_02", sdat, 8'h02);
      sel = 1'b0; idle(3);

      // write overrun: second data byte arrives while reg_we pending
      ack_dly = 5;
      sel = 1'b1; idle(3);
      send_byte(8'h10, got); idle(1);
      send_byte(8'hC3, got);
      send_byte(8'hD4, got); idle(10);
      chk("overrun_err", err, 3'b011);
      chk("overrun_wr_count", wlog_a.size(), 1);
      if (wlog_a.size() == 1) chk("overrun_wr0", {wlog_a[0], wlog_d[0]}, {7'h10, 8'hC3});
      sel = 1'b0; idle(3);
      wlog_a.delete(); wlog_d.delete();

      // timeout: no ack ever
      ack_en = 1'b0;
      sel = 1'b1; idle(3);
      send_byte(8'h85, got);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (reg_re) n++;
         else if (n > 0) break;
         @(negedge clk);
      end
      chk("timeout_re_cycles", n, 16);
      chk("timeout_err", err, 3'b111);
      chk("timeout_sdat", sdat, 8'h00);
      chk("timeout_busy", busy, 1'b1);
      sel = 1'b0; idle(2);
      chk("idle_busy", busy, 1'b0);
      ack_en = 1'b1;

      // clear command
      ack_dly = 1;
      sel = 1'b1; idle(3);
      chk("status_07", sdat, 8'h07);
      send_byte(8'hFF, got); idle(2);
      chk("clear_err", err, 3'b000);
      send_byte(8'h22, got); idle(3);
      chk("clear_ignore_busy", busy, 1'b0);
      chk("clear_ignore_wr", wlog_a.size(), 0);
      sel = 1'b0; idle(2);
      sel = 1'b1; idle(3);
      chk("status_after_clear", sdat, 8'h00);
      sel = 1'b0; idle(3);

      // abort mid-read
      ack_dly = 30;
      sel = 1'b1; idle(3);
      send_byte(8'h83, got); idle(3);
      chk("abort_re_before", reg_re, 1'b1);
      sel = 1'b0; @(negedge clk);
      chk("abort_re_after", reg_re, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_err", err, 3'b000);
      idle(3);

      // asynchronous reset mid-write
      sel = 1'b1; idle(3);
      send_byte(8'h02, got); idle(1);
      send_byte(8'h5A, got); idle(2);
      chk("pre_reset_we", {reg_we, reg_addr, reg_wdata}, {1'b1, 7'h02, 8'h5A});
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_we_re", {reg_we, reg_re}, 2'b00);
      chk("async_rst_addr", reg_addr, 7'h00);
      chk("async_rst_wdata", reg_wdata, 8'h00);
      chk("async_rst_busy_err", {busy, err}, 4'h0);
      @(negedge clk);
      sel = 1'b0; reset_n = 1'b1;
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
